// File: rtl/bcd_ripple_counter_pkg.sv
// Shared constants and digit type for the single-decade BCD counter.
package bcd_ripple_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Anything above nine cannot occur in normal counting and must be flushed.
  function automatic logic bcd_is_illegal(input bcd_digit_t d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_tff_stage.sv
// One counter bit: a flip-flop that toggles when enabled, with synchronous reset and clear.
module bcd_tff_stage (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tgl_i,
  input  logic clr_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Reset outranks clear, and clear outranks toggle.
  always_comb begin
    q_d = q_q;
    if (rst_i) begin
      q_d = 1'b0;
    end else if (clr_i) begin
      q_d = 1'b0;
    end else if (tgl_i) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk_i) begin
    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_ripple_counter.sv
// Single-decade BCD counter built from four toggle stages on a common clock.
module bcd_ripple_counter
  import bcd_ripple_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] count
);

  bcd_digit_t cur_s;
  logic [3:0] tgl_s;
  logic       clr_s;

  // Toggle enables ripple up through the lower bits; nine or an illegal code loads zero.
  always_comb begin
    tgl_s[0] = 1'b1;
    tgl_s[1] = cur_s[0];
    tgl_s[2] = &cur_s[1:0];
    tgl_s[3] = &cur_s[2:0];
    clr_s    = (cur_s == BCD_MAX) || bcd_is_illegal(cur_s);
  end

  bcd_tff_stage u_bit0 (.clk_i(clk), .rst_i(rst), .tgl_i(tgl_s[0]), .clr_i(clr_s), .q_o(cur_s[0]));
  bcd_tff_stage u_bit1 (.clk_i(clk), .rst_i(rst), .tgl_i(tgl_s[1]), .clr_i(clr_s), .q_o(cur_s[1]));
  bcd_tff_stage u_bit2 (.clk_i(clk), .rst_i(rst), .tgl_i(tgl_s[2]), .clr_i(clr_s), .q_o(cur_s[2]));
  bcd_tff_stage u_bit3 (.clk_i(clk), .rst_i(rst), .tgl_i(tgl_s[3]), .clr_i(clr_s), .q_o(cur_s[3]));

  assign count = cur_s;

endmodule

// File: tb/tb_bcd_ripple_counter.sv
// Randomized and directed check of bcd_ripple_counter against an arithmetic mod-10 model.
module tb_bcd_ripple_counter;

  logic       clk;
  logic       rst;
  logic [3:0] count;

  int total_cnt;
  int bad_cnt;
  int exp_val;

  bcd_ripple_counter dut (
    .clk  (clk),
    .rst  (rst),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int want);
    total_cnt++;
    if (got != want) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference rule: reset gives 0, an out-of-range value recovers to 0, otherwise +1 mod 10.
  function automatic int model_next(input int cur, input logic r);
    if (r) return 0;
    if (cur > 9) return 0;
    return (cur + 1) % 10;
  endfunction

  task automatic step(input logic r, input string tag);
    @(negedge clk);
    rst = r;
    @(posedge clk);
    #1;
    exp_val = model_next(exp_val, r);
    check_val(tag, int'(count), exp_val);
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    rst       = 1'b1;
    exp_val   = 0;

    @(posedge clk);
    #1;
    check_val("reset_first_edge", int'(count), 0);

    for (int i = 0; i < 10; i++) step(1'b0, "count_and_wrap");
    step(1'b1, "reset_mid");
    for (int i = 0; i < 5; i++) step(1'b0, "restart_1_to_5");

    for (int i = 0; i < 4; i++) step(1'b0, "run_to_nine");
    check_val("at_nine", int'(count), 9);
    step(1'b1, "reset_at_nine");

    for (int i = 0; i < 3; i++) step(1'b1, "reset_held");
    step(1'b0, "first_after_release");

    for (int i = 0; i < 2; i++) step(1'b0, "pre_illegal");
    @(negedge clk);
    rst = 1'b0;
    force dut.u_bit3.q_q = 1'b1;
    force dut.u_bit2.q_q = 1'b1;
    force dut.u_bit1.q_q = 1'b0;
    force dut.u_bit0.q_q = 1'b0;
    #1;
    release dut.u_bit3.q_q;
    release dut.u_bit2.q_q;
    release dut.u_bit1.q_q;
    release dut.u_bit0.q_q;
    exp_val = 12;
    @(posedge clk);
    #1;
    exp_val = model_next(exp_val, 1'b0);
    check_val("illegal_recover", int'(count), exp_val);
    step(1'b0, "after_illegal");

    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 11) == 0);
      @(posedge clk);
      #1;
      exp_val = model_next(exp_val, rst);
      check_val("random_step", int'(count), exp_val);
      check_val("random_range", int'(count <= 4'd9), 1);
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
